// File: rtl/scope_capture_multi_if.sv
// Bus bundle for scope_capture_multi: sample input, trigger/capture control, readout and status.
// The host side uses the master modport and the capture core uses the slave modport.
interface scope_capture_multi_if #(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int BUF_AW = 13
);
  // adc_valid qualifies adc_data for one cycle; there is no back-pressure, so the core
  // consumes every qualified sample it is able to store.
  logic [NCH*DW-1:0] adc_data;
  logic              adc_valid;
  logic              arm;
  logic [1:0]        trig_mode;
  logic [3:0]        trig_ch;
  logic [DW-1:0]     trig_level;
  logic              ext_trig;
  logic              force_trig;
  logic [BUF_AW-1:0] pretrig;
  logic [7:0]        decim;
  logic [3:0]        rd_ch;
  logic [BUF_AW-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic              armed;
  logic              triggered;
  logic              done;
  logic [BUF_AW-1:0] trig_addr;
  logic [2:0]        state_dbg;

  modport master (
    output adc_data, adc_valid, arm, trig_mode, trig_ch, trig_level, ext_trig,
           force_trig, pretrig, decim, rd_ch, rd_addr,
    input  rd_data, armed, triggered, done, trig_addr, state_dbg
  );

  modport slave (
    input  adc_data, adc_valid, arm, trig_mode, trig_ch, trig_level, ext_trig,
           force_trig, pretrig, decim, rd_ch, rd_addr,
    output rd_data, armed, triggered, done, trig_addr, state_dbg
  );
endinterface

// File: rtl/scope_capture_multi.sv
// Multi-channel oscilloscope capture: circular buffers, pre/post trigger record, time-ordered readout.
// Optional SCOPE_DECIMATE_EN: store only every (decim+1)th valid sample.
module scope_capture_multi #(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int BUF_AW = 13
) (
  input logic                 clk,
  input logic                 reset,
  scope_capture_multi_if.slave bus
);
  localparam int DEPTH = 1 << BUF_AW;
  localparam logic [BUF_AW:0]   DEPTH_W = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0]   ONE_W   = 1;
  localparam logic [BUF_AW-1:0] ONE_A   = 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]            mode_l;
  logic [3:0]            ch_l;
  logic signed [DW-1:0]  level_l;
  logic [BUF_AW-1:0]     pretrig_l;
  logic [BUF_AW-1:0]     wr_ptr;
  logic [BUF_AW-1:0]     trig_addr_q;
  logic [BUF_AW:0]       cnt_q;
  logic signed [DW-1:0]  prev_s;
  logic                  hist_vld;

  logic                  sample_tick;
  logic                  store;
  logic                  arm_go;
  logic                  trig_fire;
  logic                  edge_hit;
  logic signed [DW-1:0]  cur_s;
  logic [BUF_AW:0]       pre_last;

  logic [DW-1:0]         mem [NCH][DEPTH];

`ifdef SCOPE_DECIMATE_EN
  logic [7:0] decim_l;
  logic [7:0] dec_cnt;

  assign sample_tick = bus.adc_valid && (dec_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      decim_l <= '0;
      dec_cnt <= '0;
    end else if (arm_go) begin
      decim_l <= bus.decim;
      dec_cnt <= '0;
    end else if (bus.adc_valid) begin
      dec_cnt <= (dec_cnt == decim_l) ? 8'd0 : dec_cnt + 8'd1;
    end
  end
`else
  logic unused_decim;
  assign unused_decim = ^bus.decim;
  assign sample_tick  = bus.adc_valid;
`endif

  // Trigger channel sample, selected from the configuration latched at arm.
  always_comb begin
    cur_s = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_l == 4'(k)) cur_s = bus.adc_data[k*DW +: DW];
    end
  end

  always_comb begin
    edge_hit = 1'b0;
    unique case (mode_l)
      2'd0:    edge_hit = hist_vld && (prev_s < level_l) && (cur_s >= level_l);
      2'd1:    edge_hit = hist_vld && (prev_s > level_l) && (cur_s <= level_l);
      2'd2:    edge_hit = bus.ext_trig;
      default: edge_hit = 1'b0;
    endcase
  end

  assign pre_last = {1'b0, pretrig_l} - ONE_W;

  always_comb begin
    state_d   = state_q;
    store     = 1'b0;
    arm_go    = 1'b0;
    trig_fire = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.arm) begin
          arm_go  = 1'b1;
          state_d = (bus.pretrig == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        store = sample_tick;
        if (store && (cnt_q == pre_last)) state_d = S_WAIT;
      end
      S_WAIT: begin
        store     = sample_tick;
        trig_fire = (store && edge_hit) || bus.force_trig;
        if (trig_fire) state_d = S_POST;
      end
      S_POST: begin
        store = sample_tick && (cnt_q != '0);
        if ((cnt_q == '0) || (store && (cnt_q == ONE_W))) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_l      <= '0;
      ch_l        <= '0;
      level_l     <= '0;
      pretrig_l   <= '0;
      wr_ptr      <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      prev_s      <= '0;
      hist_vld    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm_go) begin
        mode_l    <= bus.trig_mode;
        ch_l      <= (int'(bus.trig_ch) < NCH) ? bus.trig_ch : 4'd0;
        level_l   <= bus.trig_level;
        pretrig_l <= bus.pretrig;
        cnt_q     <= '0;
        hist_vld  <= 1'b0;
      end else begin
        if (store) wr_ptr <= wr_ptr + ONE_A;
        if (store && (state_q == S_PRE || state_q == S_WAIT)) begin
          prev_s   <= cur_s;
          hist_vld <= 1'b1;
        end
        if (state_q == S_PRE && store) cnt_q <= cnt_q + ONE_W;
        // A forced trigger without a coincident sample makes the next stored sample the
        // trigger sample, so it is counted into the post segment to keep the record full.
        if (state_q == S_WAIT && trig_fire) begin
          trig_addr_q <= wr_ptr;
          cnt_q       <= store ? (DEPTH_W - {1'b0, pretrig_l} - ONE_W)
                               : (DEPTH_W - {1'b0, pretrig_l});
        end
        if (state_q == S_POST && store) cnt_q <= cnt_q - ONE_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      for (int k = 0; k < NCH; k++) mem[k][wr_ptr] <= bus.adc_data[k*DW +: DW];
    end
  end

  // Readout: stage 1 reads every channel at the time-ordered address, stage 2 muxes.
  logic [BUF_AW-1:0] rd_phys;
  logic [DW-1:0]     rd_word [NCH];
  logic [3:0]        rd_ch_q;
  logic [1:0]        rd_vld;
  logic [DW-1:0]     rd_sel;
  logic [DW-1:0]     rd_data_q;

  assign rd_phys = trig_addr_q - pretrig_l + bus.rd_addr;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) rd_word[k] <= mem[k][rd_phys];
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_ch_q == 4'(k)) rd_sel = rd_word[k];
    end
  end

  // rd_vld masks the pipeline until it holds data read after reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ch_q   <= '0;
      rd_vld    <= '0;
      rd_data_q <= '0;
    end else begin
      rd_ch_q   <= bus.rd_ch;
      rd_vld    <= {rd_vld[0], 1'b1};
      rd_data_q <= rd_vld[1] ? rd_sel : '0;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.armed     = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign bus.triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.trig_addr = trig_addr_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_scope_capture_multi.sv
// Directed self-checking bench for scope_capture_multi (NCH=2, DW=16, BUF_AW=4).
// Expected decimation results follow whether SCOPE_DECIMATE_EN is defined for the build.
module tb_scope_capture_multi;
  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int AW  = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  scope_capture_multi_if #(.NCH(NCH), .DW(DW), .BUF_AW(AW)) bus ();

  scope_capture_multi #(.NCH(NCH), .DW(DW), .BUF_AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c0, input int c1, input logic v);
    bus.adc_data  = {16'(c1), 16'(c0)};
    bus.adc_valid = v;
    tick();
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [3:0] ch, input int level,
                        input int pre, input int dec);
    bus.trig_mode  = mode;
    bus.trig_ch    = ch;
    bus.trig_level = 16'(level);
    bus.pretrig    = 4'(pre);
    bus.decim      = 8'(dec);
    bus.adc_valid  = 1'b0;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic read_sample(input logic [3:0] ch, input int addr, output logic [15:0] d);
    bus.rd_ch   = ch;
    bus.rd_addr = 4'(addr);
    tick();
    tick();
    d = bus.rd_data;
  endtask

  task automatic test_reset();
    bus.adc_data   = '0;
    bus.adc_valid  = 1'b0;
    bus.arm        = 1'b0;
    bus.trig_mode  = 2'd0;
    bus.trig_ch    = 4'd0;
    bus.trig_level = '0;
    bus.ext_trig   = 1'b0;
    bus.force_trig = 1'b0;
    bus.pretrig    = '0;
    bus.decim      = '0;
    bus.rd_ch      = '0;
    bus.rd_addr    = '0;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.armed !== 1'b0 || bus.triggered !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got a=%b t=%b d=%b expected 0 0 0", bus.armed, bus.triggered, bus.done);
    end
    n_checks++;
    if (bus.trig_addr !== 4'd0 || bus.state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got trig_addr=%0d state=%0d expected 0 0", bus.trig_addr, bus.state_dbg);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.rd_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_rd_data_1: got %h expected 0", bus.rd_data);
    end
    tick();
    n_checks++;
    if (bus.rd_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_rd_data_2: got %h expected 0", bus.rd_data);
    end
  endtask

  // Rising ramp capture from wr_ptr=0: trigger at sample 20, record holds 16..31.
  task automatic test_ramp(input string tag);
    logic [15:0] d;
    do_arm(2'd0, 4'd0, 20, 4, 0);
    for (int n = 0; n <= 40; n++) begin
      put(n, 1000 + n, 1'b1);
      if (n == 19) begin
        n_checks++;
        if (bus.triggered !== 1'b0 || bus.armed !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_pre_trigger: got t=%b a=%b expected 0 1", tag, bus.triggered, bus.armed);
        end
      end
      if (n == 20) begin
        n_checks++;
        if (bus.triggered !== 1'b1 || bus.trig_addr !== 4'd4) begin
          n_fail++;
          $display("FAIL %s_trigger: got t=%b addr=%0d expected 1 4", tag, bus.triggered, bus.trig_addr);
        end
      end
      if (n == 30) begin
        n_checks++;
        if (bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done_early: got %b expected 0", tag, bus.done);
        end
      end
      if (n == 31) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.armed !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done: got d=%b a=%b expected 1 0", tag, bus.done, bus.armed);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      read_sample(4'd0, i, d);
      n_checks++;
      if (d !== 16'(16 + i)) begin
        n_fail++;
        $display("FAIL %s_read_ch0[%0d]: got %0d expected %0d", tag, i, d, 16 + i);
      end
    end
    read_sample(4'd1, 0, d);
    n_checks++;
    if (d !== 16'd1016) begin
      n_fail++;
      $display("FAIL %s_read_ch1[0]: got %0d expected 1016", tag, d);
    end
    read_sample(4'd1, 15, d);
    n_checks++;
    if (d !== 16'd1031) begin
      n_fail++;
      $display("FAIL %s_read_ch1[15]: got %0d expected 1031", tag, d);
    end
    read_sample(4'd2, 3, d);
    n_checks++;
    if (d !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_read_bad_ch2: got %0d expected 0", tag, d);
    end
    read_sample(4'd15, 3, d);
    n_checks++;
    if (d !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_read_bad_ch15: got %0d expected 0", tag, d);
    end
  endtask

  // Falling trigger on ch1 with an invalid cycle (ch1=0) after every valid sample.
  task automatic test_falling();
    logic [15:0] d;
    do_arm(2'd1, 4'd1, 50, 4, 0);
    for (int n = 0; n <= 70; n++) begin
      put(500 + n, 100 - n, 1'b1);
      put(16'h7fff, 0, 1'b0);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.trig_addr !== 4'd2) begin
      n_fail++;
      $display("FAIL falling_done: got d=%b addr=%0d expected 1 2", bus.done, bus.trig_addr);
    end
    read_sample(4'd1, 4, d);
    n_checks++;
    if (d !== 16'd50) begin
      n_fail++;
      $display("FAIL falling_ch1[4]: got %0d expected 50", d);
    end
    read_sample(4'd0, 4, d);
    n_checks++;
    if (d !== 16'd550) begin
      n_fail++;
      $display("FAIL falling_ch0[4]: got %0d expected 550", d);
    end
    read_sample(4'd1, 0, d);
    n_checks++;
    if (d !== 16'd54) begin
      n_fail++;
      $display("FAIL falling_ch1[0]: got %0d expected 54", d);
    end
    read_sample(4'd1, 15, d);
    n_checks++;
    if (d !== 16'd39) begin
      n_fail++;
      $display("FAIL falling_ch1[15]: got %0d expected 39", d);
    end
  endtask

  // Force-only mode, pretrig 0, force coincident with the 7th stored sample (wr_ptr starts at 14).
  task automatic test_force();
    logic [15:0] d;
    do_arm(2'd3, 4'd0, 0, 0, 0);
    n_checks++;
    if (bus.state_dbg !== ST_WAIT) begin
      n_fail++;
      $display("FAIL force_direct_wait: got state %0d expected %0d", bus.state_dbg, ST_WAIT);
    end
    for (int n = 0; n <= 25; n++) begin
      bus.force_trig = (n == 6);
      put(200 + n, 300 + n, 1'b1);
      bus.force_trig = 1'b0;
      if (n == 5) begin
        n_checks++;
        if (bus.triggered !== 1'b0 || bus.armed !== 1'b1) begin
          n_fail++;
          $display("FAIL force_before: got t=%b a=%b expected 0 1", bus.triggered, bus.armed);
        end
      end
      if (n == 6) begin
        n_checks++;
        if (bus.triggered !== 1'b1) begin
          n_fail++;
          $display("FAIL force_triggered: got %b expected 1", bus.triggered);
        end
      end
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.trig_addr !== 4'd4) begin
      n_fail++;
      $display("FAIL force_done: got d=%b addr=%0d expected 1 4", bus.done, bus.trig_addr);
    end
    read_sample(4'd0, 0, d);
    n_checks++;
    if (d !== 16'd206) begin
      n_fail++;
      $display("FAIL force_ch0[0]: got %0d expected 206", d);
    end
    read_sample(4'd0, 15, d);
    n_checks++;
    if (d !== 16'd221) begin
      n_fail++;
      $display("FAIL force_ch0[15]: got %0d expected 221", d);
    end
    read_sample(4'd1, 1, d);
    n_checks++;
    if (d !== 16'd307) begin
      n_fail++;
      $display("FAIL force_ch1[1]: got %0d expected 307", d);
    end
  endtask

  // Crossing inside PRE is ignored; capture sits in WAIT and ignores a second arm.
  task automatic test_pre_crossing();
    do_arm(2'd0, 4'd0, 20, 8, 0);
    for (int n = 0; n < 8; n++) put(15 + n, 0, 1'b1);
    for (int n = 0; n < 20; n++) put(30, 0, 1'b1);
    n_checks++;
    if (bus.state_dbg !== ST_WAIT || bus.armed !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_cross_wait: got state=%0d a=%b expected %0d 1", bus.state_dbg, bus.armed, ST_WAIT);
    end
    n_checks++;
    if (bus.done !== 1'b0 || bus.triggered !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_cross_flags: got d=%b t=%b expected 0 0", bus.done, bus.triggered);
    end
    do_arm(2'd3, 4'd1, 0, 0, 0);
    put(30, 0, 1'b1);
    put(30, 0, 1'b1);
    n_checks++;
    if (bus.state_dbg !== ST_WAIT || bus.armed !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_ignored: got state=%0d a=%b expected %0d 1", bus.state_dbg, bus.armed, ST_WAIT);
    end
  endtask

  // Continues from WAIT: a rising crossing (original latched config) enters POST, then reset.
  task automatic test_reset_in_post();
    put(10, 0, 1'b1);
    put(25, 0, 1'b1);
    n_checks++;
    if (bus.triggered !== 1'b1) begin
      n_fail++;
      $display("FAIL post_entered: got t=%b expected 1", bus.triggered);
    end
    put(26, 0, 1'b1);
    put(27, 0, 1'b1);
    n_checks++;
    if (bus.state_dbg !== ST_POST) begin
      n_fail++;
      $display("FAIL post_state: got %0d expected %0d", bus.state_dbg, ST_POST);
    end
    reset = 1'b1;
    put(28, 0, 1'b1);
    n_checks++;
    if (bus.armed !== 1'b0 || bus.triggered !== 1'b0 || bus.done !== 1'b0 || bus.trig_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_flags: got a=%b t=%b d=%b addr=%0d expected 0 0 0 0",
               bus.armed, bus.triggered, bus.done, bus.trig_addr);
    end
    reset = 1'b0;
    bus.adc_valid = 1'b0;
    bus.rd_ch = 4'd0;
    bus.rd_addr = 4'd5;
    tick();
    n_checks++;
    if (bus.rd_data !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_rd_1: got %h expected 0", bus.rd_data);
    end
    tick();
    n_checks++;
    if (bus.rd_data !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_rd_2: got %h expected 0", bus.rd_data);
    end
    test_ramp("rearm");
  endtask

  task automatic test_decimation();
    logic [15:0] d;
    int exp_v;
    do_arm(2'd0, 4'd0, 20, 4, 2);
    for (int n = 0; n <= 60; n++) put(n, 0, 1'b1);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL decim_done: got %b expected 1", bus.done);
    end
    for (int i = 0; i < 16; i++) begin
`ifdef SCOPE_DECIMATE_EN
      exp_v = 9 + 3 * i;
`else
      exp_v = 16 + i;
`endif
      read_sample(4'd0, i, d);
      n_checks++;
      if (d !== 16'(exp_v)) begin
        n_fail++;
        $display("FAIL decim_read[%0d]: got %0d expected %0d", i, d, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp("ramp");
    test_falling();
    test_force();
    test_pre_crossing();
    test_reset_in_post();
    test_decimation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scope_capture_multi.md
SCOPE_CAPTURE_MULTI -- requirements
Module: scope_capture_multi

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of captured channels (1..16).
REQ-002 The block SHALL have parameter DW, default 16, signed sample width per channel.
REQ-003 The block SHALL have parameter BUF_AW, default 13, per-channel buffer address width (depth 2^BUF_AW).
REQ-004 clk  input  1  sole clock; all logic, sampling and readout on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 adc_data  input  NCH*DW  channel k at bits [k*DW +: DW].
REQ-007 adc_valid  input  1  qualifies adc_data for the current cycle.
REQ-008 arm  input  1  single-cycle pulse starting a capture.
REQ-009 trig_mode  input  2  0 rising, 1 falling, 2 external, 3 force-only.
REQ-010 trig_ch  input  4  channel compared against trig_level.
REQ-011 trig_level  input  DW  signed threshold.
REQ-012 ext_trig  input  1  external trigger, level, sampled on stored samples.
REQ-013 force_trig  input  1  single-cycle software trigger pulse.
REQ-014 pretrig  input  BUF_AW  samples retained before the trigger sample.
REQ-015 decim  input  8  decimation factor minus one.
REQ-016 rd_ch  input  4, rd_addr  input  BUF_AW  readout channel and time-ordered sample index.
REQ-017 rd_data  output  DW  readout sample.
REQ-018 armed, triggered, done  output  1 each  status flags; trig_addr  output  BUF_AW  raw buffer address of trigger sample.

Function
REQ-019 States SHALL be IDLE, PRE, WAIT, POST, DONE; arm in IDLE or DONE goes to PRE (or WAIT if pretrig==0); arm elsewhere ignored.
REQ-020 A stored sample SHALL write all NCH channels at the common circular pointer wr_ptr, which increments modulo 2^BUF_AW.
REQ-021 PRE SHALL store exactly pretrig samples, then go to WAIT; triggers in PRE are ignored.
REQ-022 In WAIT, rising SHALL fire when previous stored sample < trig_level and current >= trig_level (signed, channel trig_ch); falling the mirror; external on ext_trig high at a stored sample.
REQ-023 force_trig in WAIT SHALL fire on the next cycle regardless of trig_mode; if force_trig and a stored sample coincide, the sample's address is the trigger address.
REQ-024 The trigger sample SHALL be stored, trig_addr latched to its address, triggered set, state to POST.
REQ-025 POST SHALL store 2^BUF_AW - pretrig - 1 further samples, then DONE; total record is exactly 2^BUF_AW samples.
REQ-026 In DONE writes SHALL stop, done=1, buffer frozen until next arm.
REQ-027 trig_ch >= NCH SHALL select channel 0; rd_ch >= NCH SHALL return zero.
REQ-028 rd_data SHALL equal buffer[rd_ch][(trig_addr - pretrig + rd_addr) mod 2^BUF_AW] with 2-cycle latency, valid in any state.
REQ-029 armed SHALL be 1 in PRE/WAIT/POST; triggered 1 in POST/DONE; done 1 in DONE only.
REQ-030 Changing pretrig, trig_* or decim while armed SHALL take effect only at next arm (latched on arm).

Reset
REQ-031 reset SHALL force IDLE, armed=triggered=done=0, trig_addr=0, wr_ptr=0, decimation counter=0, edge history cleared; buffer contents not cleared.
REQ-032 Reset mid-capture SHALL abandon the capture; subsequent arm starts cleanly.
REQ-033 rd_data SHALL be 0 for the two cycles following reset release.

Configuration
REQ-034 With SCOPE_DECIMATE_EN defined, a stored sample SHALL occur every (decim+1)th valid sample, counter restarting on arm; trigger evaluation uses stored samples only.
REQ-035 Without SCOPE_DECIMATE_EN, decim SHALL be ignored and every valid sample stored.

Verification (NCH=2, DW=16, BUF_AW=4)
REQ-036 Ramp ch0 = 0..40 every cycle, rising, level 20, pretrig 4, arm -> trigger at sample 20; rd_addr 0..15 reads 16..31; done after 11 post samples.
REQ-037 Falling mode, ch1 = 100-n, level 50, trig_ch 1 -> rd_addr 4 reads 50; ch0 captured at same addresses.
REQ-038 trig_mode 3, pretrig 0, force_trig at 7th stored sample -> rd_addr 0 is that sample; triggered same cycle+1.
REQ-039 Level crossing during PRE then none in WAIT -> stays WAIT, armed=1, done=0; arm pulse ignored.
REQ-040 reset asserted in POST -> all flags 0 next cycle; new arm completes normally.
REQ-041 SCOPE_DECIMATE_EN, decim 2, ramp ch0 -> stored values step by 3; without macro step by 1.
